// File: rtl/pipe_scheduler.sv
`default_nettype none
// pipe_scheduler: scrolls three recycled pipe obstacles, presents the current pipe's edges and keeps score.
// Revision: 1.0
module pipe_scheduler #(
  parameter int PIPE_WIDTH = 40,
  parameter int SPACING    = 220,
  parameter int SPEED      = 2,
  parameter int START_X    = 680,
  parameter int GAP_BASE   = 60,
  parameter int GAP_H      = 120
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_lose,
  input  logic       i_tick,
  input  logic [9:0] i_bird_x_l,
  output logic [9:0] o_x_edge_left,
  output logic [9:0] o_x_edge_right,
  output logic [9:0] o_y_edge_top,
  output logic [9:0] o_y_edge_bottom,
  output logic       o_pipe_valid,
  output logic [7:0] o_score,
  output logic       o_score_pulse
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD0 = 3'd1;
  localparam logic [2:0] S_LOAD1 = 3'd2;
  localparam logic [2:0] S_LOAD2 = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;

  localparam logic [10:0] c_speed   = 11'(SPEED);
  localparam logic [10:0] c_respawn = 11'(3 * SPACING - SPEED);
  localparam logic [9:0]  c_pw      = 10'(PIPE_WIDTH);
  localparam logic [9:0]  c_gap_h   = 10'(GAP_H);

  logic [2:0]  r_state;
  logic [7:0]  r_lfsr;
  logic [10:0] r_pos [3];
  logic [8:0]  r_gap [3];
  logic [1:0]  r_cur;
  logic [7:0]  r_score;
  logic        r_score_pulse;

  logic        w_move;
  logic        w_point;
  logic [10:0] w_cur_pos;
  logic [8:0]  w_cur_gap;
  logic [8:0]  w_gap_new;
  logic [9:0]  w_xr;

  assign w_move    = (r_state == S_RUN) && i_tick && !i_lose;
  assign w_gap_new = 9'(GAP_BASE) + {1'b0, r_lfsr};

  always_comb begin
    w_cur_pos = r_pos[0];
    w_cur_gap = r_gap[0];
    case (r_cur)
      2'd1: begin w_cur_pos = r_pos[1]; w_cur_gap = r_gap[1]; end
      2'd2: begin w_cur_pos = r_pos[2]; w_cur_gap = r_gap[2]; end
      default: ;
    endcase
  end

  // A point is earned when the bird has cleared the current pipe or it scrolls off this cycle.
  assign w_point = (r_state == S_RUN) &&
                   ((w_cur_pos < {1'b0, i_bird_x_l}) || (w_move && (w_cur_pos <= c_speed)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_lfsr        <= 8'hA5;
      r_cur         <= 2'd0;
      r_score       <= 8'd0;
      r_score_pulse <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        r_pos[k] <= 11'(START_X + k * SPACING);
        r_gap[k] <= 9'd0;
      end
    end else begin
      r_lfsr        <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      r_score_pulse <= w_point;
      case (r_state)
        S_IDLE: if (i_start) r_state <= S_LOAD0;
        S_LOAD0: r_state <= S_LOAD1;
        S_LOAD1: r_state <= S_LOAD2;
        S_LOAD2: r_state <= S_RUN;
        S_RUN:   if (i_lose) r_state <= S_HALT;
        S_HALT:  if (i_start) r_state <= S_LOAD0;
        default: r_state <= S_IDLE;
      endcase

      if (r_state == S_IDLE || r_state == S_LOAD0) begin
        r_cur   <= 2'd0;
        r_score <= 8'd0;
        for (int k = 0; k < 3; k++) r_pos[k] <= 11'(START_X + k * SPACING);
      end else if (w_point) begin
        r_cur <= (r_cur == 2'd2) ? 2'd0 : r_cur + 2'd1;
        if (r_score != 8'hFF) r_score <= r_score + 8'd1;
      end

      if (r_state == S_LOAD0) r_gap[0] <= w_gap_new;
      if (r_state == S_LOAD1) r_gap[1] <= w_gap_new;
      if (r_state == S_LOAD2) r_gap[2] <= w_gap_new;

      if (w_move) begin
        for (int k = 0; k < 3; k++) begin
          if (r_pos[k] > c_speed) begin
            r_pos[k] <= r_pos[k] - c_speed;
          end else begin
            r_pos[k] <= r_pos[k] + c_respawn;
            r_gap[k] <= w_gap_new;
          end
        end
      end
    end
  end

  assign w_xr         = (w_cur_pos > 11'd1023) ? 10'd1023 : w_cur_pos[9:0];
  assign o_pipe_valid = (r_state == S_RUN) || (r_state == S_HALT);
  assign o_score      = r_score;
  assign o_score_pulse = r_score_pulse;

  // Invalid edges are parked so that no overlap with the bird is possible.
  always_comb begin
    o_x_edge_right  = 10'd1023;
    o_x_edge_left   = 10'd1023;
    o_y_edge_top    = 10'd0;
    o_y_edge_bottom = 10'd1023;
    if (o_pipe_valid) begin
      o_x_edge_right  = w_xr;
      o_x_edge_left   = (w_xr < c_pw) ? 10'd0 : w_xr - c_pw;
      o_y_edge_top    = {1'b0, w_cur_gap};
      o_y_edge_bottom = {1'b0, w_cur_gap} + c_gap_h;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_scheduler.sv
`default_nettype none
// tb_pipe_scheduler: directed stimulus with a scoreboard checking every score pulse.
// Revision: 1.0
module tb_pipe_scheduler;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_lose = 1'b0;
  logic       i_tick = 1'b0;
  logic [9:0] i_bird_x_l = 10'd0;
  logic [9:0] o_x_edge_left, o_x_edge_right, o_y_edge_top, o_y_edge_bottom;
  logic       o_pipe_valid, o_score_pulse;
  logic [7:0] o_score;

  pipe_scheduler dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_lose(i_lose),
    .i_tick(i_tick), .i_bird_x_l(i_bird_x_l),
    .o_x_edge_left(o_x_edge_left), .o_x_edge_right(o_x_edge_right),
    .o_y_edge_top(o_y_edge_top), .o_y_edge_bottom(o_y_edge_bottom),
    .o_pipe_valid(o_pipe_valid), .o_score(o_score), .o_score_pulse(o_score_pulse)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0] score;
    logic [9:0] xr;
    logic [9:0] yt;
  } exp_t;

  exp_t       r_q[$];
  int         n_checks = 0;
  int         n_err = 0;
  logic [7:0] m_lfsr;
  logic [8:0] g [3];

  // Reference LFSR, seeded and stepped exactly as the gap generator is defined.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) m_lfsr <= 8'hA5;
    else          m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n && o_score_pulse) begin
      if (r_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = r_q.pop_front();
        chk("pulse_score", int'(o_score), int'(e.score));
        chk("pulse_xr", int'(o_x_edge_right), int'(e.xr));
        chk("pulse_ytop", int'(o_y_edge_top), int'(e.yt));
      end
    end
  end

  task automatic tick_n(input int n, output logic [7:0] lf);
    i_tick = 1'b1;
    lf = m_lfsr;
    for (int i = 0; i < n; i++) begin
      lf = m_lfsr;
      @(negedge i_clk);
    end
    i_tick = 1'b0;
  endtask

  task automatic do_start();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("load_valid", int'(o_pipe_valid), 0);
      g[k] = 9'd60 + {1'b0, m_lfsr};
      @(negedge i_clk);
    end
    chk("start_valid", int'(o_pipe_valid), 1);
    chk("start_xr", int'(o_x_edge_right), 680);
    chk("start_xl", int'(o_x_edge_left), 640);
    chk("start_ytop", int'(o_y_edge_top), int'(g[0]));
    chk("start_ybot", int'(o_y_edge_bottom), int'(g[0]) + 120);
    chk("start_score", int'(o_score), 0);
  endtask

  initial begin
    logic [7:0] lf;
    logic [8:0] gnew0;
    int fp [3];
    exp_t e;

    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Idle: ticks have no effect and edges are parked.
    tick_n(100, lf);
    chk("idle_valid", int'(o_pipe_valid), 0);
    chk("idle_xr", int'(o_x_edge_right), 1023);
    chk("idle_xl", int'(o_x_edge_left), 1023);
    chk("idle_ytop", int'(o_y_edge_top), 0);
    chk("idle_ybot", int'(o_y_edge_bottom), 1023);
    chk("idle_score", int'(o_score), 0);
    chk("idle_pulse", int'(o_score_pulse), 0);

    do_start();

    // Bird at 100: point when the first pipe's right edge drops below it.
    i_bird_x_l = 10'd100;
    tick_n(291, lf);
    chk("pass_before_xr", int'(o_x_edge_right), 98);
    chk("pass_before_score", int'(o_score), 0);
    e = '{score: 8'd1, xr: 10'd316, yt: {1'b0, g[1]}};
    r_q.push_back(e);
    tick_n(1, lf);
    chk("pass_score", int'(o_score), 1);

    // Lose together with Tick: halt without movement, then stay frozen.
    i_lose = 1'b1;
    i_tick = 1'b1;
    @(negedge i_clk);
    i_lose = 1'b0;
    i_tick = 1'b0;
    chk("halt_xr", int'(o_x_edge_right), 316);
    chk("halt_valid", int'(o_pipe_valid), 1);
    tick_n(20, lf);
    chk("halt_frozen_xr", int'(o_x_edge_right), 316);
    chk("halt_frozen_score", int'(o_score), 1);
    chk("halt_frozen_ytop", int'(o_y_edge_top), int'(g[1]));
    i_bird_x_l = 10'd0;
    do_start();

    // Bird at 0: points only from recycling.
    tick_n(339, lf);
    chk("edge_xr", int'(o_x_edge_right), 2);
    chk("edge_xl_clamp", int'(o_x_edge_left), 0);
    e = '{score: 8'd1, xr: 10'd220, yt: {1'b0, g[1]}};
    r_q.push_back(e);
    tick_n(1, lf);
    gnew0 = 9'd60 + {1'b0, lf};
    chk("recycle_score", int'(o_score), 1);
    e = '{score: 8'd2, xr: 10'd220, yt: {1'b0, g[2]}};
    r_q.push_back(e);
    e = '{score: 8'd3, xr: 10'd220, yt: {1'b0, gnew0}};
    r_q.push_back(e);
    tick_n(220, lf);
    chk("recycle_score3", int'(o_score), 3);
    chk("recycle_ybot", int'(o_y_edge_bottom), int'(gnew0) + 120);
    i_lose = 1'b1;
    @(negedge i_clk);
    i_lose = 1'b0;
    do_start();

    // Saturation: a point every cycle with the bird at the far right.
    tick_n(60, lf);
    fp[0] = 560; fp[1] = 780; fp[2] = 1000;
    for (int k = 1; k <= 260; k++) begin
      e.score = (k > 255) ? 8'd255 : 8'(k);
      e.xr    = 10'(fp[k % 3]);
      e.yt    = {1'b0, g[k % 3]};
      r_q.push_back(e);
    end
    i_bird_x_l = 10'd1023;
    repeat (260) @(negedge i_clk);
    i_bird_x_l = 10'd0;
    @(negedge i_clk);
    chk("sat_score", int'(o_score), 255);
    chk("sat_pulse_off", int'(o_score_pulse), 0);
    chk("sb_empty", r_q.size(), 0);

    // Asynchronous reset between clock edges.
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rst_valid", int'(o_pipe_valid), 0);
    chk("rst_xr", int'(o_x_edge_right), 1023);
    chk("rst_xl", int'(o_x_edge_left), 1023);
    chk("rst_ytop", int'(o_y_edge_top), 0);
    chk("rst_ybot", int'(o_y_edge_bottom), 1023);
    chk("rst_score", int'(o_score), 0);
    chk("rst_pulse", int'(o_score_pulse), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
